// File: rtl/flex_pts_if.sv
// Load handshake and serial stream bundle for flex_pts_serializer.
// master drives words and shift strobes; slave is the serializer.
interface flex_pts_if #(
    parameter int NUM_BITS  = 8,
    parameter int OUT_WIDTH = 1
);
    logic                 load_valid;
    logic                 load_ready;
    logic [NUM_BITS-1:0]  parallel_in;
    logic                 shift_enable;
    logic                 abort;
    logic [OUT_WIDTH-1:0] serial_out;
    logic                 busy;
    logic                 word_done;

    modport master (
        output load_valid, parallel_in, shift_enable, abort,
        input  load_ready, serial_out, busy, word_done
    );

    modport slave (
        input  load_valid, parallel_in, shift_enable, abort,
        output load_ready, serial_out, busy, word_done
    );
endinterface

// File: rtl/flex_pts_serializer.sv
// Double-buffered parallel-to-serial shifter emitting OUT_WIDTH-bit chunks,
// with a one-word holding buffer so consecutive words stream without gaps.
module flex_pts_serializer #(
    parameter int   NUM_BITS  = 8,
    parameter int   OUT_WIDTH = 1,
    parameter bit   SHIFT_MSB = 1'b1,
    parameter logic IDLE_VAL  = 1'b1
) (
    input logic       clk,
    input logic       n_rst,
    flex_pts_if.slave bus
);
    localparam int NUM_CHUNKS = NUM_BITS / OUT_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 2) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0]     LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [NUM_BITS-1:0]  FILL_WORD  = {NUM_BITS{IDLE_VAL}};
    localparam logic [OUT_WIDTH-1:0] FILL_CHUNK = {OUT_WIDTH{IDLE_VAL}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    count, next_count;
    logic [NUM_BITS-1:0] hold, next_hold;
    logic                hold_full, next_hold_full;
    logic [NUM_BITS-1:0] shift_reg, next_shift_reg;
    logic                word_done, next_word_done;
    logic [NUM_BITS-1:0] shifted;

    // Direction only changes which end is emitted and which end is refilled.
    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign shifted        = {shift_reg[NUM_BITS-OUT_WIDTH-1:0], FILL_CHUNK};
            assign bus.serial_out = shift_reg[NUM_BITS-1 -: OUT_WIDTH];
        end else begin : g_lsb_first
            assign shifted        = {FILL_CHUNK, shift_reg[NUM_BITS-1:OUT_WIDTH]};
            assign bus.serial_out = shift_reg[OUT_WIDTH-1:0];
        end
    endgenerate

    assign bus.load_ready = !hold_full;
    assign bus.busy       = (state == SHIFT);
    assign bus.word_done  = word_done;

    always_comb begin
        // NOTE: every next_* gets its current value first so no path infers a latch.
        next_state     = state;
        next_count     = count;
        next_hold      = hold;
        next_hold_full = hold_full;
        next_shift_reg = shift_reg;
        next_word_done = 1'b0;

        if (bus.abort) begin
            next_state     = IDLE;
            next_count     = '0;
            next_hold_full = 1'b0;
            next_shift_reg = FILL_WORD;
        end else begin
            // Acceptance needs an empty buffer and transfer needs a full one,
            // so the two never collide on the same edge.
            if (bus.load_valid && !hold_full) begin
                next_hold      = bus.parallel_in;
                next_hold_full = 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        next_shift_reg = hold;
                        next_hold_full = 1'b0;
                        next_count     = '0;
                        next_state     = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.shift_enable) begin
                        if (count == LAST_CHUNK) begin
                            next_word_done = 1'b1;
                            next_count     = '0;
                            if (hold_full) begin
                                next_shift_reg = hold;
                                next_hold_full = 1'b0;
                            end else begin
                                next_shift_reg = FILL_WORD;
                                next_state     = IDLE;
                            end
                        end else begin
                            next_shift_reg = shifted;
                            next_count     = count + CNT_W'(1);
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            count     <= '0;
            // NOTE: hold is only read while hold_full is set; resetting it just keeps it X-free.
            hold      <= FILL_WORD;
            hold_full <= 1'b0;
            shift_reg <= FILL_WORD;
            word_done <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge next_* values.
            state     <= next_state;
            count     <= next_count;
            hold      <= next_hold;
            hold_full <= next_hold_full;
            shift_reg <= next_shift_reg;
            word_done <= next_word_done;
        end
    end
endmodule

// File: tb/tb_flex_pts_serializer.sv
// Directed bench: MSB-first 1-bit instance (dut_a) and LSB-first 2-bit instance (dut_b).
module tb_flex_pts_serializer;
    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    flex_pts_if #(.NUM_BITS(8), .OUT_WIDTH(1)) ifa ();
    flex_pts_if #(.NUM_BITS(8), .OUT_WIDTH(2)) ifb ();

    flex_pts_serializer #(.NUM_BITS(8), .OUT_WIDTH(1), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) dut_a (
        .clk(clk), .n_rst(n_rst), .bus(ifa)
    );
    flex_pts_serializer #(.NUM_BITS(8), .OUT_WIDTH(2), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) dut_b (
        .clk(clk), .n_rst(n_rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] word);
        ifa.load_valid  = 1'b1;
        ifa.parallel_in = word;
        tick();
        ifa.load_valid  = 1'b0;
    endtask

    task automatic idle_a(input string tag);
        check({tag, "_serial"}, 16'(ifa.serial_out), 16'h1);
        check({tag, "_busy"},   16'(ifa.busy),       16'h0);
        check({tag, "_done"},   16'(ifa.word_done),  16'h0);
        check({tag, "_ready"},  16'(ifa.load_ready), 16'h1);
    endtask

    // n consecutive strobes; seq holds the expected bits, first-out at bit n-1.
    task automatic stream_a(input string tag, input logic [15:0] seq, input int n);
        ifa.shift_enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_bit"}, 16'(ifa.serial_out), 16'(seq[n-1-i]));
            tick();
            check({tag, "_done"}, 16'(ifa.word_done), ((i + 1) % 8 == 0) ? 16'h1 : 16'h0);
        end
        ifa.shift_enable = 1'b0;
        check({tag, "_end_serial"}, 16'(ifa.serial_out), 16'h1);
        check({tag, "_end_busy"},   16'(ifa.busy),       16'h0);
        check({tag, "_end_ready"},  16'(ifa.load_ready), 16'h1);
        tick();
        check({tag, "_done_clear"}, 16'(ifa.word_done), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  w1;
        logic [15:0] seq2;
        logic [1:0]  exp_b [4];

        n_rst = 1'b0;
        ifa.load_valid = 1'b0; ifa.parallel_in = '0; ifa.shift_enable = 1'b0; ifa.abort = 1'b0;
        ifb.load_valid = 1'b0; ifb.parallel_in = '0; ifb.shift_enable = 1'b0; ifb.abort = 1'b0;

        // Reset state
        #12;
        idle_a("rst_a");
        check("rst_b_serial", 16'(ifb.serial_out), 16'h3);
        check("rst_b_busy",   16'(ifb.busy),       16'h0);
        check("rst_b_ready",  16'(ifb.load_ready), 16'h1);
        #1;
        n_rst = 1'b1;
        tick();

        // Test 1: 0xA5, strobes spaced three cycles apart
        w1 = 8'hA5;
        load_a(w1);
        check("t1_ready_after_accept", 16'(ifa.load_ready), 16'h0);
        check("t1_busy_before_xfer",   16'(ifa.busy),       16'h0);
        tick();
        check("t1_busy_after_xfer",  16'(ifa.busy),       16'h1);
        check("t1_ready_after_xfer", 16'(ifa.load_ready), 16'h1);
        for (int i = 0; i < 8; i++) begin
            check("t1_bit", 16'(ifa.serial_out), 16'(w1[7-i]));
            ifa.shift_enable = 1'b1;
            tick();
            ifa.shift_enable = 1'b0;
            if (i < 7) begin
                check("t1_done_mid", 16'(ifa.word_done), 16'h0);
                tick();
                tick();
            end
        end
        check("t1_done_pulse", 16'(ifa.word_done), 16'h1);
        check("t1_end_serial", 16'(ifa.serial_out), 16'h1);
        check("t1_end_busy",   16'(ifa.busy),       16'h0);
        check("t1_end_ready",  16'(ifa.load_ready), 16'h1);
        tick();
        check("t1_done_clear", 16'(ifa.word_done), 16'h0);

        // Test 2: back-to-back 0xA5 then 0x3C with 16 consecutive strobes
        load_a(8'hA5);
        tick();
        load_a(8'h3C);
        check("t2_ready_hold_full", 16'(ifa.load_ready), 16'h0);
        check("t2_busy",            16'(ifa.busy),       16'h1);
        seq2 = 16'hA53C;
        ifa.shift_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_bit", 16'(ifa.serial_out), 16'(seq2[15-i]));
            tick();
            check("t2_done",  16'(ifa.word_done),  (i == 7 || i == 15) ? 16'h1 : 16'h0);
            check("t2_busy",  16'(ifa.busy),       (i != 15) ? 16'h1 : 16'h0);
            check("t2_ready", 16'(ifa.load_ready), (i >= 7) ? 16'h1 : 16'h0);
        end
        ifa.shift_enable = 1'b0;
        check("t2_end_serial", 16'(ifa.serial_out), 16'h1);
        tick();
        check("t2_done_clear", 16'(ifa.word_done), 16'h0);

        // Test 3: LSB-first, 2-bit chunks, 0xB4
        exp_b = '{2'b00, 2'b01, 2'b11, 2'b10};
        ifb.load_valid  = 1'b1;
        ifb.parallel_in = 8'hB4;
        tick();
        ifb.load_valid  = 1'b0;
        tick();
        check("t3_busy", 16'(ifb.busy), 16'h1);
        ifb.shift_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_chunk", 16'(ifb.serial_out), 16'(exp_b[i]));
            tick();
            check("t3_done", 16'(ifb.word_done), (i == 3) ? 16'h1 : 16'h0);
        end
        ifb.shift_enable = 1'b0;
        check("t3_end_serial", 16'(ifb.serial_out), 16'h3);
        check("t3_end_busy",   16'(ifb.busy),       16'h0);
        tick();
        check("t3_done_clear", 16'(ifb.word_done), 16'h0);

        // Test 4: load attempt while the holding buffer is full is ignored
        load_a(8'h0F);
        tick();
        load_a(8'h69);
        ifa.load_valid  = 1'b1;
        ifa.parallel_in = 8'hFF;
        tick();
        check("t4_ready_blocked", 16'(ifa.load_ready), 16'h0);
        tick();
        check("t4_ready_blocked2", 16'(ifa.load_ready), 16'h0);
        ifa.load_valid = 1'b0;
        stream_a("t4", 16'h0F69, 16);

        // Test 5: abort mid-word together with a load
        load_a(8'hA5);
        tick();
        ifa.shift_enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ifa.shift_enable = 1'b0;
        check("t5_pre_abort_bit", 16'(ifa.serial_out), 16'h0);
        ifa.abort       = 1'b1;
        ifa.load_valid  = 1'b1;
        ifa.parallel_in = 8'h00;
        tick();
        ifa.abort      = 1'b0;
        ifa.load_valid = 1'b0;
        idle_a("t5_after_abort");
        ifa.shift_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_a("t5_post_strobe");
        end
        ifa.shift_enable = 1'b0;

        // Test 6: asynchronous reset mid-word with the holding buffer full
        load_a(8'hA5);
        tick();
        ifa.shift_enable = 1'b1;
        tick();
        tick();
        ifa.shift_enable = 1'b0;
        load_a(8'h00);
        check("t6_ready_hold_full", 16'(ifa.load_ready), 16'h0);
        #3;
        n_rst = 1'b0;
        #1;
        idle_a("t6_async_rst");
        #2;
        n_rst = 1'b1;
        tick();
        idle_a("t6_after_rst");
        load_a(8'h81);
        tick();
        stream_a("t6", 16'h0081, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
